// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request/response sequencer in front of the 32-bit ALU.
// Define OVF_TRAP_EN to turn signed overflow on ADD/SUB/MOVE into a trap.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  alu_command,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        rsp_taken,
  output logic        rsp_err,
  output logic        rsp_trap
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_MOVE = 4'd10;
  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;

  localparam logic [3:0] CNT_INIT =
    4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;

  logic [2:0]  dec_cmd;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  always_comb begin
    dec_cmd = CMD_ADD;
    dec_a   = req_a;
    dec_b   = req_b;
    unique case (1'b1)
      (req_op < OP_BEQ):
        dec_cmd = req_op[2:0];
      (req_op == OP_BEQ),
      (req_op == OP_BNE):
        dec_cmd = CMD_SUB;
      (req_op == OP_MOVE):
        dec_b = '0;
      default: begin
        dec_a = '0;
        dec_b = '0;
      end
    endcase
  end

  logic [31:0] smp_result;
  logic [2:0]  smp_flags;
  logic        smp_taken;
  logic        smp_err;
  logic        smp_trap;

  always_comb begin
    smp_result = alu_result;
    smp_flags  = {alu_overflow, alu_carryout, alu_zero};
    smp_taken  = 1'b0;
    smp_err    = 1'b0;
    smp_trap   = 1'b0;
    unique case (1'b1)
      (op_q == OP_BEQ):
        smp_taken = alu_zero;
      (op_q == OP_BNE):
        smp_taken = ~alu_zero;
      (op_q > OP_MOVE): begin
        smp_result = '0;
        smp_flags  = '0;
        smp_err    = 1'b1;
      end
      default: ;
    endcase
`ifdef OVF_TRAP_EN
    // Branch compares use SUB too but must never trap.
    if ((op_q == OP_ADD || op_q == OP_SUB ||
         op_q == OP_MOVE) && alu_overflow) begin
      smp_trap   = 1'b1;
      smp_result = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      req_ready    <= 1'b1;
      alu_command  <= CMD_ADD;
      alu_operandA <= '0;
      alu_operandB <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_taken    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_trap     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q         <= req_op;
            alu_command  <= dec_cmd;
            alu_operandA <= dec_a;
            alu_operandB <= dec_b;
            cnt          <= CNT_INIT;
            req_ready    <= 1'b0;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            rsp_result <= smp_result;
            rsp_flags  <= smp_flags;
            rsp_taken  <= smp_taken;
            rsp_err    <= smp_err;
            rsp_trap   <= smp_trap;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random checks of alu_issue_ctrl
// against an op-level reference model, with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  alu_command;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_taken;
  logic        rsp_err;
  logic        rsp_trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_command(alu_command),
    .alu_operandA(alu_operandA),
    .alu_operandB(alu_operandB),
    .alu_result(alu_result),
    .alu_carryout(alu_carryout),
    .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_taken(rsp_taken), .rsp_err(rsp_err),
    .rsp_trap(rsp_trap)
  );

  // Behavioural ALU: flags only meaningful for ADD/SUB.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      3'd0, 3'd1: begin
        if (alu_command == 3'd0)
          alu_sum = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        else
          alu_sum = {1'b0, alu_operandA} + {1'b0, ~alu_operandB}
                    + 33'd1;
        alu_result   = alu_sum[31:0];
        alu_carryout = alu_sum[32];
        alu_zero     = (alu_sum[31:0] == 32'd0);
        alu_overflow =
          (alu_operandA[31] == (alu_operandB[31] ^ alu_command[0]))
          && (alu_sum[31] != alu_operandA[31]);
      end
      3'd2: alu_result = alu_operandA ^ alu_operandB;
      3'd3: alu_result =
        {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
      3'd4: alu_result = alu_operandA & alu_operandB;
      3'd5: alu_result = ~(alu_operandA & alu_operandB);
      3'd6: alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
  end

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
    logic        taken;
    logic        err;
    logic        trap;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    logic is_sub, arith, ovf, cy, z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.cmd = 3'd0; e.a = a; e.b = b; e.res = '0;
    e.flags = '0; e.taken = 0; e.err = 0; e.trap = 0;
    is_sub = (op == 1 || op == 8 || op == 9);
    arith  = (op == 0 || is_sub || op == 10);
    case (op)
      4'd0: e.res = a + b;
      4'd1, 4'd8, 4'd9: e.res = a - b;
      4'd2: e.res = a ^ b;
      4'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: e.res = a & b;
      4'd5: e.res = ~(a & b);
      4'd6: e.res = ~(a | b);
      4'd7: e.res = a | b;
      4'd10: e.res = a;
      default: e.res = '0;
    endcase
    if (op <= 7) e.cmd = op[2:0];
    if (is_sub) e.cmd = 3'd1;
    if (op == 10) e.b = '0;
    if (op > 10) begin
      e.a = '0; e.b = '0; e.err = 1;
    end
    if (arith) begin
      if (op == 10) s = sa;
      else if (is_sub) s = sa - sb;
      else s = sa + sb;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (is_sub) cy = (a >= b);
      else if (op == 10) cy = 1'b0;
      else cy = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
      z = (e.res == 0);
      e.flags = {ovf, cy, z};
      if (op == 8) e.taken = z;
      if (op == 9) e.taken = !z;
`ifdef OVF_TRAP_EN
      if (ovf && (op == 0 || op == 1 || op == 10)) begin
        e.trap = 1;
        e.res  = '0;
      end
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input exp_t e);
    chk({tag, "_cmd"}, 32'(alu_command), 32'(e.cmd));
    chk({tag, "_opa"}, alu_operandA, e.a);
    chk({tag, "_opb"}, alu_operandB, e.b);
  endtask

  task automatic chk_rsp(input string tag, input exp_t e);
    chk({tag, "_res"}, rsp_result, e.res);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(e.flags));
    chk({tag, "_taken"}, 32'(rsp_taken), 32'(e.taken));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, "_trap"}, 32'(rsp_trap), 32'(e.trap));
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    e = model(op, a, b);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    chk("accepted", 32'(req_ready), 32'd0);
    chk("no_early_rsp", 32'(rsp_valid), 32'd0);
    chk_alu("issue", e);
  endtask

  task automatic run(input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int stall);
    exp_t e;
    e = model(op, a, b);
    issue(op, a, b);
    for (int i = 1; i < S; i++) begin
      @(negedge clk);
      chk("settle_valid", 32'(rsp_valid), 32'd0);
      chk_alu("settle", e);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk_alu("held", e);
    chk_rsp("rsp", e);
    req_valid = (stall > 0);
    req_op = 4'($urandom_range(0, 15));
    req_a = $urandom; req_b = $urandom;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk_rsp("stall", e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_idle", 32'(req_ready), 32'd1);
    chk_rsp("kept", e);
  endtask

  initial begin
    exp_t z;
    logic [3:0]  op;
    logic [31:0] a, b;
    z = model(4'd15, 32'd0, 32'd0);
    z.err = 0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk_alu("rst", z);
    chk_rsp("rst", z);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
    run(4'd8, 32'd5, 32'd5, 0);
    run(4'd9, 32'd5, 32'd5, 0);
    run(4'd9, 32'd5, 32'd6, 1);
    run(4'd3, 32'hFFFF_FFFF, 32'h1, 0);
    run(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    run(4'd10, 32'h8000_0000, 32'hDEAD_BEEF, 0);
    run(4'd1, 32'h8000_0000, 32'h1, 2);

    // Asynchronous reset while the request is in DRIVE.
    issue(4'd7, 32'hF0F0_0000, 32'h0000_0F0F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk_alu("mid_rst", z);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);

    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
